// File: rtl/cache_pkg.sv
// Shared types and helpers for the LRU miss allocator.
// Optional feature: LRU_ALLOC_INVALID_FIRST_EN (invalid ways are filled before evicting).
package cache_pkg;

    localparam int MAX_WAYS = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WB,
        S_FILL,
        S_ALLOC
    } alloc_state_e;

    function automatic logic onehot_ok(input logic [MAX_WAYS-1:0] v);
        return (v != '0) && ((v & (v - MAX_WAYS'(1))) == '0);
    endfunction

    // Lowest clear bit of v as a one-hot vector (zero if v is all ones).
    function automatic logic [MAX_WAYS-1:0] lowest_zero_onehot(
        input logic [MAX_WAYS-1:0] v
    );
        return ~v & (v + MAX_WAYS'(1));
    endfunction

endpackage

// File: rtl/victim_select.sv
// Victim choice: validates the LRU one-hot target and, when
// LRU_ALLOC_INVALID_FIRST_EN is defined, prefers the lowest invalid way.
module victim_select
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-1:0] target,
    input  logic                ready,
    input  logic [NUM_WAYS-1:0] valid_ways,
    output logic                victim_valid,
    output logic [NUM_WAYS-1:0] victim_onehot
);

    logic [MAX_WAYS-1:0] target_ext;
    logic                lru_ok;

    assign target_ext = MAX_WAYS'(target);
    assign lru_ok     = ready & onehot_ok(target_ext);

`ifdef LRU_ALLOC_INVALID_FIRST_EN
    logic [MAX_WAYS-1:0] pad_valid;
    logic [MAX_WAYS-1:0] free_ext;
    logic [NUM_WAYS-1:0] free_way;
    logic                unused_free;

    // Ways above NUM_WAYS read as valid so they are never picked.
    assign pad_valid   = ~MAX_WAYS'(~valid_ways);
    assign free_ext    = lowest_zero_onehot(pad_valid);
    assign free_way    = free_ext[NUM_WAYS-1:0];
    assign unused_free = ^free_ext;

    always_comb begin
        victim_valid  = lru_ok;
        victim_onehot = target;
        if (valid_ways != '1) begin
            victim_valid  = 1'b1;
            victim_onehot = free_way;
        end
    end
`else
    logic unused_valid;

    assign unused_valid  = ^valid_ways;
    assign victim_valid  = lru_ok;
    assign victim_onehot = target;
`endif

endmodule

// File: rtl/lru_miss_allocator.sv
// Miss sequencer between tag/dirty arrays, LRU policy and memory port.
// Optional feature: LRU_ALLOC_INVALID_FIRST_EN (see victim_select).
module lru_miss_allocator
    import cache_pkg::*;
#(
    parameter int NUM_WAYS   = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic [NUM_WAYS-1:0]   evictionTarget,
    input  logic                  evictionReady,
    input  logic [NUM_WAYS-1:0]   dirtyWays,
    input  logic [NUM_WAYS-1:0]   validWays,
    output logic                  wb_req,
    output logic [NUM_WAYS-1:0]   wb_way,
    input  logic                  wb_ack,
    output logic                  fill_req,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic                  fill_ack,
    output logic [NUM_WAYS-1:0]   allocateWay,
    output logic                  alloc_done
);

    alloc_state_e        state;
    alloc_state_e        state_nx;
    logic [NUM_WAYS-1:0] victim;
    logic                sel_valid;
    logic [NUM_WAYS-1:0] sel_onehot;
    logic                sel_dirty;

    victim_select #(
        .NUM_WAYS(NUM_WAYS)
    ) u_victim_select (
        .target       (evictionTarget),
        .ready        (evictionReady),
        .valid_ways   (validWays),
        .victim_valid (sel_valid),
        .victim_onehot(sel_onehot)
    );

    assign sel_dirty = |(sel_onehot & dirtyWays);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            fill_addr <= '0;
            victim    <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && miss_valid) begin
                fill_addr <= miss_addr;
            end
            // Victim is captured once; later target changes are ignored.
            if (state == S_SELECT && sel_valid) begin
                victim <= sel_onehot;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (miss_valid) state_nx = S_SELECT;
            end
            S_SELECT: begin
                if (sel_valid) state_nx = sel_dirty ? S_WB : S_FILL;
            end
            S_WB: begin
                if (wb_ack) state_nx = S_FILL;
            end
            S_FILL: begin
                if (fill_ack) state_nx = S_ALLOC;
            end
            S_ALLOC: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        miss_ready  = 1'b0;
        wb_req      = 1'b0;
        wb_way      = '0;
        fill_req    = 1'b0;
        allocateWay = '0;
        alloc_done  = 1'b0;
        unique case (state)
            S_IDLE:  miss_ready = 1'b1;
            S_WB: begin
                wb_req = 1'b1;
                wb_way = victim;
            end
            S_FILL:  fill_req = 1'b1;
            S_ALLOC: begin
                allocateWay = victim;
                alloc_done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lru_miss_allocator.sv
// Directed bench for lru_miss_allocator (NUM_WAYS=4).
module tb_lru_miss_allocator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic [3:0]  evictionTarget;
    logic        evictionReady;
    logic [3:0]  dirtyWays;
    logic [3:0]  validWays;
    logic        wb_req;
    logic [3:0]  wb_way;
    logic        wb_ack;
    logic        fill_req;
    logic [31:0] fill_addr;
    logic        fill_ack;
    logic [3:0]  allocateWay;
    logic        alloc_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lru_miss_allocator #(
        .NUM_WAYS  (4),
        .ADDR_WIDTH(32)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .evictionTarget(evictionTarget),
        .evictionReady (evictionReady),
        .dirtyWays     (dirtyWays),
        .validWays     (validWays),
        .wb_req        (wb_req),
        .wb_way        (wb_way),
        .wb_ack        (wb_ack),
        .fill_req      (fill_req),
        .fill_addr     (fill_addr),
        .fill_ack      (fill_ack),
        .allocateWay   (allocateWay),
        .alloc_done    (alloc_done)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    // Present a miss at a negedge; the next posedge is the handshake.
    task automatic start_miss(input logic [31:0] a);
        chk("idle_ready", 64'(miss_ready), 64'(1));
        miss_valid = 1'b1;
        miss_addr  = a;
        @(negedge clk);
        miss_valid = 1'b0;
        miss_addr  = '0;
    endtask

    initial begin
        reset_n        = 1'b0;
        miss_valid     = 1'b0;
        miss_addr      = '0;
        evictionTarget = '0;
        evictionReady  = 1'b0;
        dirtyWays      = '0;
        validWays      = 4'b1111;
        wb_ack         = 1'b0;
        fill_ack       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(miss_ready), 64'(1));
        chk("rst_wb", 64'(wb_req), 64'(0));
        chk("rst_fill", 64'(fill_req), 64'(0));
        chk("rst_addr", 64'(fill_addr), 64'(0));
        chk("rst_alloc", 64'(allocateWay), 64'(0));
        chk("rst_done", 64'(alloc_done), 64'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // 1: clean miss, cycle-exact latency
        evictionReady  = 1'b1;
        evictionTarget = 4'b0100;
        fill_ack       = 1'b1;
        start_miss(32'h1000);
        chk("t1_sel_ready", 64'(miss_ready), 64'(0));
        chk("t1_sel_fill", 64'(fill_req), 64'(0));
        chk("t1_addr", 64'(fill_addr), 64'h1000);
        @(negedge clk);
        chk("t1_fill", 64'(fill_req), 64'(1));
        chk("t1_fill_wb", 64'(wb_req), 64'(0));
        @(negedge clk);
        chk("t1_alloc", 64'(allocateWay), 64'(4'b0100));
        chk("t1_done", 64'(alloc_done), 64'(1));
        chk("t1_alloc_fill", 64'(fill_req), 64'(0));
        fill_ack = 1'b0;
        @(negedge clk);
        chk("t1_after", 64'(allocateWay), 64'(0));
        chk("t1_after_done", 64'(alloc_done), 64'(0));

        // 2: dirty miss, wb_ack after 5 cycles with fill_ack alongside
        evictionTarget = 4'b1000;
        dirtyWays      = 4'b1000;
        start_miss(32'h2040);
        chk("t2_sel_wb", 64'(wb_req), 64'(0));
        @(negedge clk);
        evictionTarget = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            chk("t2_wb", 64'(wb_req), 64'(1));
            chk("t2_wb_way", 64'(wb_way), 64'(4'b1000));
            chk("t2_wb_nofill", 64'(fill_req), 64'(0));
            if (i == 4) begin
                wb_ack   = 1'b1;
                fill_ack = 1'b1;
            end
            @(negedge clk);
        end
        wb_ack = 1'b0;
        chk("t2_wb_drop", 64'(wb_req), 64'(0));
        chk("t2_fill", 64'(fill_req), 64'(1));
        chk("t2_addr", 64'(fill_addr), 64'h2040);
        @(negedge clk);
        fill_ack = 1'b0;
        chk("t2_alloc", 64'(allocateWay), 64'(4'b1000));
        chk("t2_done", 64'(alloc_done), 64'(1));
        @(negedge clk);
        dirtyWays = '0;

        // 3: evictionReady low for 4 cycles, slow fill_ack
        evictionReady = 1'b0;
        start_miss(32'h3000);
        for (int i = 0; i < 4; i++) begin
            chk("t3_stall_wb", 64'(wb_req), 64'(0));
            chk("t3_stall_fill", 64'(fill_req), 64'(0));
            chk("t3_stall_rdy", 64'(miss_ready), 64'(0));
            if (i < 3) @(negedge clk);
        end
        evictionReady  = 1'b1;
        evictionTarget = 4'b0001;
        @(negedge clk);
        chk("t3_fill0", 64'(fill_req), 64'(1));
        @(negedge clk);
        chk("t3_fill1", 64'(fill_req), 64'(1));
        fill_ack = 1'b1;
        @(negedge clk);
        fill_ack = 1'b0;
        chk("t3_alloc", 64'(allocateWay), 64'(4'b0001));
        @(negedge clk);

        // 4: non-one-hot target held off, then a clean target
        evictionTarget = 4'b0110;
        dirtyWays      = 4'b0110;
        start_miss(32'h4000);
        for (int i = 0; i < 2; i++) begin
            chk("t4_bad_wb", 64'(wb_req), 64'(0));
            chk("t4_bad_fill", 64'(fill_req), 64'(0));
            if (i == 1) begin
                evictionTarget = 4'b0010;
                dirtyWays      = 4'b0100;
                fill_ack       = 1'b1;
            end
            @(negedge clk);
        end
        chk("t4_fill", 64'(fill_req), 64'(1));
        chk("t4_nowb", 64'(wb_req), 64'(0));
        @(negedge clk);
        fill_ack = 1'b0;
        chk("t4_alloc", 64'(allocateWay), 64'(4'b0010));
        @(negedge clk);

        // 5: reset while writeback outstanding
        evictionTarget = 4'b0001;
        dirtyWays      = 4'b0001;
        start_miss(32'h5000);
        @(negedge clk);
        chk("t5_wb", 64'(wb_req), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_wb", 64'(wb_req), 64'(0));
        chk("t5_async_way", 64'(wb_way), 64'(0));
        chk("t5_async_rdy", 64'(miss_ready), 64'(1));
        @(negedge clk);
        reset_n = 1'b1;
        wb_ack  = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_late_rdy", 64'(miss_ready), 64'(1));
        chk("t5_late_wb", 64'(wb_req), 64'(0));
        chk("t5_late_fill", 64'(fill_req), 64'(0));
        chk("t5_addr", 64'(fill_addr), 64'(0));
        wb_ack    = 1'b0;
        dirtyWays = '0;

`ifdef LRU_ALLOC_INVALID_FIRST_EN
        // 6: invalid way taken without evictionReady
        validWays      = 4'b1011;
        evictionReady  = 1'b0;
        evictionTarget = 4'b1000;
        fill_ack       = 1'b1;
        start_miss(32'h6000);
        @(negedge clk);
        chk("t6_nowb", 64'(wb_req), 64'(0));
        chk("t6_fill", 64'(fill_req), 64'(1));
        @(negedge clk);
        fill_ack = 1'b0;
        chk("t6_alloc", 64'(allocateWay), 64'(4'b0100));
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
